// File: rtl/alu_seq_pkg.sv
// Purpose: shared FSM state and operation encodings for the bit-serial ALU sequencer and its slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // Operation select encodings shared with the 1-bit slice
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/ALU_1bit.sv
// Purpose: 1-bit ALU slice (AND/OR/ADD/XOR with optional B inversion), ripple carry out.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module ALU_1bit
    import alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic b_eff;

    assign b_eff = b ^ binvert;

    // Full-adder carry is always produced; the sequencer decides when it matters
    assign cout = (a & b_eff) | (cin & (a ^ b_eff));

    // Operation mux
    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = a & b_eff;
            OP_OR:   result = a | b_eff;
            OP_ADD:  result = a ^ b_eff ^ cin;
            OP_XOR:  result = a ^ b_eff;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Purpose: bit-serial WIDTH-bit ALU, one bit per clock LSB first through a single ALU_1bit slice; optional Overflow output under `ALU_SEQ_OVF_EN.
// Latency: Done pulses WIDTH+1 cycles after the accepting Start (WIDTH RUN cycles, then one DONE cycle).
// Backpressure: Start is only accepted in IDLE; Start while Busy or during Done is dropped, not queued.
module alu_serial_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BInvert,
    input  logic             CarryIn,
    input  logic [1:0]       Operation,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
`ifdef ALU_SEQ_OVF_EN
    output logic             Carry,
    output logic             Overflow
`else
    output logic             Carry
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             binv_q;
    logic [1:0]       op_q;
    logic             carry_q;

    logic             slice_res;
    logic             slice_cout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign accept   = (state == S_IDLE) && Start;
    assign last_bit = (state == S_RUN) && (cnt == LAST_BIT);
    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB
    assign res_next = {slice_res, res_sr};

    assign Busy = (state == S_RUN);
    assign Done = (state == S_DONE);

    ALU_1bit u_slice (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .binvert   (binv_q),
        .cin       (carry_q),
        .operation (op_q),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    // Control FSM and bit counter: IDLE -> RUN for WIDTH cycles -> DONE for one cycle -> IDLE
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand latch on accept, then shift one bit per RUN cycle with the carry held in a flop
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            binv_q  <= 1'b0;
            op_q    <= OP_AND;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_sr    <= A;
            b_sr    <= B;
            res_sr  <= '0;
            binv_q  <= BInvert;
            op_q    <= Operation;
            carry_q <= CarryIn;
        end else if (state == S_RUN) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr  <= res_next[WIDTH-1:1];
            carry_q <= slice_cout;
        end
    end

    // Visible result and flags change only on the final RUN edge and hold until the next completion
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            Overflow <= 1'b0;
`endif
        end else if (last_bit) begin
            Result   <= res_next;
            Zero     <= (res_next == '0);
            Carry    <= (op_q == OP_ADD) && slice_cout;
`ifdef ALU_SEQ_OVF_EN
            // carry_q is the carry into the MSB, slice_cout the carry out of it
            Overflow <= (op_q == OP_ADD) && (carry_q ^ slice_cout);
`endif
        end
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
module tb_alu_serial_sequencer;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BInvert = 1'b0;
    logic         CarryIn = 1'b0;
    logic [1:0]   Operation = 2'b00;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Carry;
`ifdef ALU_SEQ_OVF_EN
    logic         Overflow;
`endif

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .BInvert   (BInvert),
        .CarryIn   (CarryIn),
        .Operation (Operation),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Zero      (Zero),
`ifdef ALU_SEQ_OVF_EN
        .Carry     (Carry),
        .Overflow  (Overflow)
`else
        .Carry     (Carry)
`endif
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    always @(posedge Clock) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic binv, input logic cin, input logic [1:0] op,
                                 output logic [W-1:0] r, output logic c, output logic ov);
        logic [W-1:0] be;
        logic [W:0]   s;
        be = binv ? ~b : b;
        c  = 1'b0;
        ov = 1'b0;
        case (op)
            2'd0: r = a & be;
            2'd1: r = a | be;
            2'd2: begin
                s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin};
                r  = s[W-1:0];
                c  = s[W];
                ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
            end
            default: r = a ^ be;
        endcase
    endfunction

    // cd counts cycles left in the current operation: W+1 at accept, 1 during the Done cycle, 0 idle
    int           cd = 0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_z = 1'b0, m_c = 1'b0, m_ov = 1'b0;
    logic         p_z = 1'b0, p_c = 1'b0, p_ov = 1'b0;

    always @(posedge Clock or posedge Reset) begin : model
        logic [W-1:0] r;
        logic         c, ov;
        if (Reset) begin
            cd    <= 0;
            m_res <= '0;
            m_z   <= 1'b0;
            m_c   <= 1'b0;
            m_ov  <= 1'b0;
        end else if (cd == 0) begin
            if (Start) begin
                calc(A, B, BInvert, CarryIn, Operation, r, c, ov);
                p_res <= r;
                p_z   <= (r == '0);
                p_c   <= c;
                p_ov  <= ov;
                cd    <= W + 1;
            end
        end else begin
            cd <= cd - 1;
            if (cd == 2) begin
                m_res <= p_res;
                m_z   <= p_z;
                m_c   <= p_c;
                m_ov  <= p_ov;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge Clock) begin
        chk("busy",   32'(Busy),   32'(cd > 1));
        chk("done",   32'(Done),   32'(cd == 1));
        chk("result", 32'(Result), 32'(m_res));
        chk("zero",   32'(Zero),   32'(m_z));
        chk("carry",  32'(Carry),  32'(m_c));
`ifdef ALU_SEQ_OVF_EN
        chk("overflow", 32'(Overflow), 32'(m_ov));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic binv, input logic cin, input logic [1:0] op);
        @(posedge Clock);
        #2;
        A = a; B = b; BInvert = binv; CarryIn = cin; Operation = op;
        Start = 1'b1;
        @(posedge Clock);
        #2;
        Start = 1'b0;
    endtask

    // Cycle 1 is the cycle that starts at the accepting edge
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (Busy) busy_cnt++;
            if (Done) begin
                cyc = k;
                return;
            end
        end
        chk("done timeout", 32'(0), 32'(1));
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic binv, input logic cin, input logic [1:0] op,
                         input logic [W-1:0] er, input logic ez, input logic ec);
        int cyc, bc;
        start_op(a, b, binv, cin, op);
        wait_done(cyc, bc);
        chk({nm, " result"},  32'(Result), 32'(er));
        chk({nm, " zero"},    32'(Zero),   32'(ez));
        chk({nm, " carry"},   32'(Carry),  32'(ec));
        chk({nm, " latency"}, 32'(cyc),    32'(17));
        chk({nm, " busy"},    32'(bc),     32'(16));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int cyc, bc, n;
        int t[3];

        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst busy",   32'(Busy),   32'(0));
        chk("rst done",   32'(Done),   32'(0));
        chk("rst result", 32'(Result), 32'(0));
        chk("rst zero",   32'(Zero),   32'(0));
        chk("rst carry",  32'(Carry),  32'(0));
        #1;
        Reset = 1'b0;

        do_op("add",   16'h1234, 16'h0FF0, 1'b0, 1'b0, 2'b10, 16'h2224, 1'b0, 1'b0);
        do_op("sub1",  16'h0005, 16'h0007, 1'b1, 1'b1, 2'b10, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub2",  16'h1234, 16'h1234, 1'b1, 1'b1, 2'b10, 16'h0000, 1'b1, 1'b1);
        do_op("xor",   16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 2'b11, 16'h5555, 1'b0, 1'b0);
        do_op("and",   16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 2'b00, 16'hAAAA, 1'b0, 1'b0);
        do_op("or",    16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 2'b01, 16'hFFFF, 1'b0, 1'b0);
        do_op("ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b10, 16'h8000, 1'b0, 1'b0);
`ifdef ALU_SEQ_OVF_EN
        chk("ovf overflow", 32'(Overflow), 32'(1));
`endif

        // Start during RUN and during DONE must be ignored
        start_op(16'h0100, 16'h0011, 1'b0, 1'b0, 2'b10);
        repeat (5) @(posedge Clock);
        #2;
        A = 16'hFFFF; B = 16'hFFFF; Operation = 2'b11; Start = 1'b1;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        wait_done(cyc, bc);
        chk("ign run result", 32'(Result), 32'(16'h0111));
        A = 16'h5A5A; B = 16'h0F0F; Operation = 2'b01; Start = 1'b1;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        chk("ign done result", 32'(Result), 32'(16'h0111));
        chk("ign done busy",   32'(Busy),   32'(0));

        // Start held high: back-to-back operations
        @(posedge Clock);
        #2;
        A = 16'h0003; B = 16'h0004; BInvert = 1'b0; CarryIn = 1'b0; Operation = 2'b10;
        Start = 1'b1;
        n = 0;
        for (int k = 0; k < 80 && n < 3; k++) begin
            @(negedge Clock);
            if (Done) begin
                t[n] = cycle;
                n++;
                if (n == 3) Start = 1'b0;
            end
        end
        Start = 1'b0;
        chk("b2b count", 32'(n), 32'(3));
        if (n == 3) begin
            chk("b2b gap1", 32'(t[1] - t[0]), 32'(18));
            chk("b2b gap2", 32'(t[2] - t[1]), 32'(18));
        end
        chk("b2b result", 32'(Result), 32'(16'h0007));

        // Randomized operations, some with ignored Start pulses mid-run
        for (int i = 0; i < 150; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 14)) @(posedge Clock);
                #2;
                A = 16'($urandom); B = 16'($urandom); Operation = 2'($urandom);
                Start = 1'b1;
                @(posedge Clock);
                #2;
                Start = 1'b0;
            end
            wait_done(cyc, bc);
            chk("rand done seen", 32'(cyc != 0), 32'(1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clock);
        end

        // Asynchronous reset mid-RUN
        start_op(16'h4000, 16'h4000, 1'b0, 1'b0, 2'b10);
        repeat (8) @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst busy",   32'(Busy),   32'(0));
        chk("arst done",   32'(Done),   32'(0));
        chk("arst result", 32'(Result), 32'(0));
        chk("arst zero",   32'(Zero),   32'(0));
        chk("arst carry",  32'(Carry),  32'(0));
`ifdef ALU_SEQ_OVF_EN
        chk("arst overflow", 32'(Overflow), 32'(0));
`endif
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        do_op("post rst add", 16'h0001, 16'h0001, 1'b0, 1'b0, 2'b10, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(negedge Clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
